fetch: RTL and testbench
========================

# fetch

Byte-serial Y86-64 fetch stage sitting directly upstream of the decode stage. Starting from an internal PC, it reads instruction bytes one at a time from instruction memory over a req/ack handshake and assembles icode, ifun, rA, rB, valC and valP. It presents each complete instruction to decode through a valid/ready handshake, and it accepts PC redirects from later stages for jumps, calls and returns.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_o  out  1  byte read request; held high until acked.
- imem_addr_o  out  64  byte address, equal to PC + idx; stable while req is high.
- imem_ack_i  in  1  read complete this cycle; only meaningful while req is high.
- imem_data_i  in  8  read byte, valid with ack.
- imem_err_i  in  1  address fault, valid with ack.
- valid_o  out  1  instruction bundle valid.
- ready_i  in  1  decode accepts the bundle.
- icode_o, ifun_o, rA_o, rB_o  out  4 each  instruction fields.
- valC_o  out  64  constant word, little-endian assembled; 0 if the instruction has none.
- valP_o  out  64  PC + instruction length.
- stat_o  out  3  1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- pc_load_i  in  1  redirect strobe.
- pc_new_i  in  64  redirect target.

## Operation
- Byte 0 carries icode in bits [7:4] and ifun in bits [3:0].
- Byte 1, when present, carries rA in bits [7:4] and rB in bits [3:0].
- valC occupies bytes 1..8 for jXX and call, and bytes 2..9 for irmovq, rmmovq and mrmovq.
- Instruction lengths:
  - halt (0), nop (1), ret (9): 1 byte.
  - rrmovq/cmov (2), OPq (6), pushq (A), popq (B): 2 bytes.
  - jXX (7), call (8): 9 bytes.
  - irmovq (3), rmmovq (4), mrmovq (5): 10 bytes.
  - icode C..F: invalid.
- Fields not carried by the instruction read as rA = rB = 4'hF and valC = 0.
- ifun is passed through unchecked.
- States:
  - FETCH: req = 1, addr = PC + idx. On ack, capture the byte into its field and increment idx (4 bits). Go to OUT once idx + 1 equals the instruction length. Length is decided from byte 0 in the cycle it is acked.
  - OUT: valid = 1 with the bundle stable. On valid & ready, PC <= valP and idx <= 0; the next state is FETCH, or HALTED if stat is not AOK.
  - HALTED: req = 0 and valid = 0. Left only by reset.
- Status:
  - halt emits stat HLT.
  - An invalid icode emits immediately after byte 0 with stat INS and valP = PC + 1.
  - imem_err_i on any ack emits immediately with stat ADR. Fields captured so far are kept, the rest read as defaults, and valP = PC + idx + 1.
- Redirect (pc_load_i = 1) in FETCH or OUT:
  - PC <= pc_new_i, idx <= 0, next state FETCH.
  - Any ack in the same cycle is discarded.
  - A pending bundle is dropped even if ready_i is high that cycle.
  - Redirect in HALTED is ignored.
- Reset has priority over redirect and ack. Reset mid-fetch drops everything, and no ack is honoured in the reset cycle.
- PC arithmetic is 64-bit and wraps modulo 2^64; there is no fault on wrap.

## Timing
- Reset values:
  - State FETCH, PC = RESET_PC, idx = 0.
  - valid_o = 0 and imem_req_o = 0 during reset.
  - icode_o = ifun_o = 0, rA_o = rB_o = F, valC_o = valP_o = 0, stat_o = AOK.
- imem_req_o rises in the first cycle after rst_i deasserts.
- With zero-wait memory (ack in the same cycle as req), an N-byte instruction takes N FETCH cycles. valid_o rises the cycle after the last ack.
- Each wait cycle adds one cycle.
- Sustained throughput is N + 1 cycles per instruction: one OUT cycle plus N byte cycles. The next req starts the cycle after the handshake.
- Output fields update only on entry to OUT and stay stable while valid_o = 1 and ready_i = 0.
- imem_addr_o is stable while imem_req_o = 1 and no redirect occurs.

## Test plan
- Zero-wait memory holds 10 00 60 23 from address 0; ready_i tied high. Expected:
  - First bundle: nop, valP = 1, stat = 1.
  - Second bundle: halt, stat = 2, valP = 2.
  - Then no further req in any later cycle.
- Memory holds 30 F2 0A 00 00 00 00 00 00 00 with 2 wait cycles per byte; ready_i low for 3 cycles. Expected:
  - icode = 3, rA = F, rB = 2, valC = 10, valP = 10.
  - Bundle stable through the stall; the next req is at address 10.
- Memory holds 80 34 12 00 00 00 00 00 00 (call), then pc_load_i with target 0x1234. Expected:
  - valC = 0x1234, valP = 9.
  - The next req after the redirect is at address 0x1234.
- Memory holds C0 at PC 0 → one bundle with stat = 4, icode = C, valP = 1; then HALTED with req low.
- mrmovq at 0x40 with imem_err_i on its byte-3 ack → bundle with stat = 3, icode = 5, valP = 0x44; then HALTED.
- Redirect to 0x100 during byte 5 of an irmovq; rst_i pulsed while in OUT. Expected:
  - The partial instruction is never emitted, and the next addr is 0x100.
  - After reset, valid_o = 0 and the next addr equals RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// Byte-serial Y86-64 fetch stage.
// Reads one instruction byte per memory handshake, assembles the
// icode/ifun/rA/rB/valC/valP bundle and hands it to decode through a
// valid/ready handshake. Later stages may redirect the PC at any time
// outside HALTED.
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [7:0]  imem_data_i,
  input  logic        imem_err_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic [2:0]  stat_o,
  input  logic        pc_load_i,
  input  logic [63:0] pc_new_i
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_OUT   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Instruction length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] f_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       f_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
      4'h7, 4'h8:             f_len = 4'd9;
      4'h3, 4'h4, 4'h5:       f_len = 4'd10;
      default:                f_len = 4'd0;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [63:0] r_pc;
  logic [3:0]  r_idx;

  // Fields accumulated so far for the instruction being fetched.
  logic [3:0]  r_a_icode, r_a_ifun, r_a_ra, r_a_rb;
  logic [63:0] r_a_valc;

  // Bundle registers presented to decode.
  logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
  logic [63:0] r_valc, r_valp;
  logic [2:0]  r_stat;

  // Combinational view of the fetch step for the byte acked this cycle.
  logic [3:0]  w_len;
  logic [2:0]  w_lane;
  logic        w_jc;
  logic [3:0]  w_base_icode, w_base_ifun, w_base_ra, w_base_rb;
  logic [63:0] w_base_valc;
  logic [3:0]  w_cap_icode, w_cap_ifun, w_cap_ra, w_cap_rb;
  logic [63:0] w_cap_valc;
  logic [3:0]  w_out_icode, w_out_ifun, w_out_ra, w_out_rb;
  logic [63:0] w_out_valc, w_out_valp;
  logic [2:0]  w_out_stat;
  logic        w_done;

  // Merge the incoming byte into the fields and decide whether the bundle is complete.
  always_comb begin
    // Length comes from byte 0 on its own ack cycle, afterwards from the stored icode.
    w_len = (r_idx == 4'd0) ? f_len(imem_data_i[7:4]) : f_len(r_a_icode);
    w_jc  = (r_a_icode == 4'h7) || (r_a_icode == 4'h8);
    // jXX/call carry valC from byte 1, the move-with-constant forms from byte 2.
    w_lane = w_jc ? (r_idx[2:0] - 3'd1) : (r_idx[2:0] - 3'd2);

    // A new instruction starts from defaults; later bytes build on what is stored.
    if (r_idx == 4'd0) begin
      w_base_icode = 4'h0;
      w_base_ifun  = 4'h0;
      w_base_ra    = 4'hF;
      w_base_rb    = 4'hF;
      w_base_valc  = 64'd0;
    end else begin
      w_base_icode = r_a_icode;
      w_base_ifun  = r_a_ifun;
      w_base_ra    = r_a_ra;
      w_base_rb    = r_a_rb;
      w_base_valc  = r_a_valc;
    end

    w_cap_icode = w_base_icode;
    w_cap_ifun  = w_base_ifun;
    w_cap_ra    = w_base_ra;
    w_cap_rb    = w_base_rb;
    w_cap_valc  = w_base_valc;
    if (r_idx == 4'd0) begin
      w_cap_icode = imem_data_i[7:4];
      w_cap_ifun  = imem_data_i[3:0];
    end else if (w_jc || r_idx != 4'd1) begin
      w_cap_valc[{w_lane, 3'b000} +: 8] = imem_data_i;
    end else begin
      w_cap_ra = imem_data_i[7:4];
      w_cap_rb = imem_data_i[3:0];
    end

    w_done      = 1'b0;
    w_out_icode = w_cap_icode;
    w_out_ifun  = w_cap_ifun;
    w_out_ra    = w_cap_ra;
    w_out_rb    = w_cap_rb;
    w_out_valc  = w_cap_valc;
    w_out_valp  = r_pc + {60'd0, w_len};
    w_out_stat  = STAT_AOK;
    if (imem_err_i) begin
      // The faulting byte itself is not captured.
      w_done      = 1'b1;
      w_out_icode = w_base_icode;
      w_out_ifun  = w_base_ifun;
      w_out_ra    = w_base_ra;
      w_out_rb    = w_base_rb;
      w_out_valc  = w_base_valc;
      w_out_valp  = r_pc + {60'd0, r_idx} + 64'd1;
      w_out_stat  = STAT_ADR;
    end else if (w_len == 4'd0) begin
      w_done     = 1'b1;
      w_out_valp = r_pc + 64'd1;
      w_out_stat = STAT_INS;
    end else if ((r_idx + 4'd1) == w_len) begin
      w_done     = 1'b1;
      w_out_stat = (w_cap_icode == 4'h0) ? STAT_HLT : STAT_AOK;
    end
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (pc_load_i) begin
          w_state_next = ST_FETCH;
        end else if (imem_ack_i && w_done) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (pc_load_i) begin
          w_state_next = ST_FETCH;
        end else if (ready_i) begin
          w_state_next = (r_stat == STAT_AOK) ? ST_FETCH : ST_HALT;
        end
      end
      default: w_state_next = ST_HALT;
    endcase
  end

  // Handshake outputs, held low while reset is asserted.
  always_comb begin
    imem_req_o  = (r_state == ST_FETCH) && !rst_i;
    valid_o     = (r_state == ST_OUT) && !rst_i;
    imem_addr_o = r_pc + {60'd0, r_idx};
  end

  assign icode_o = r_icode;
  assign ifun_o  = r_ifun;
  assign rA_o    = r_ra;
  assign rB_o    = r_rb;
  assign valC_o  = r_valc;
  assign valP_o  = r_valp;
  assign stat_o  = r_stat;

  // PC, byte index, field accumulation and bundle capture on entry to OUT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc      <= RESET_PC;
      r_idx     <= 4'd0;
      r_a_icode <= 4'h0;
      r_a_ifun  <= 4'h0;
      r_a_ra    <= 4'hF;
      r_a_rb    <= 4'hF;
      r_a_valc  <= 64'd0;
      r_icode   <= 4'h0;
      r_ifun    <= 4'h0;
      r_ra      <= 4'hF;
      r_rb      <= 4'hF;
      r_valc    <= 64'd0;
      r_valp    <= 64'd0;
      r_stat    <= STAT_AOK;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (pc_load_i) begin
            r_pc  <= pc_new_i;
            r_idx <= 4'd0;
          end else if (imem_ack_i) begin
            r_a_icode <= w_cap_icode;
            r_a_ifun  <= w_cap_ifun;
            r_a_ra    <= w_cap_ra;
            r_a_rb    <= w_cap_rb;
            r_a_valc  <= w_cap_valc;
            if (w_done) begin
              r_icode <= w_out_icode;
              r_ifun  <= w_out_ifun;
              r_ra    <= w_out_ra;
              r_rb    <= w_out_rb;
              r_valc  <= w_out_valc;
              r_valp  <= w_out_valp;
              r_stat  <= w_out_stat;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        ST_OUT: begin
          if (pc_load_i) begin
            r_pc  <= pc_new_i;
            r_idx <= 4'd0;
          end else if (ready_i) begin
            r_pc  <= r_valp;
            r_idx <= 4'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: a byte memory model with
// configurable wait states and fault address, a scoreboard of expected
// bundles popped on every decode handshake, a table of instruction
// vectors and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_fetch;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [7:0]  imem_data_i = 8'h00;
  logic        imem_err_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
  logic [63:0] valC_o, valP_o;
  logic [2:0]  stat_o;
  logic        pc_load_i = 1'b0;
  logic [63:0] pc_new_i = 64'd0;

  fetch #(.RESET_PC(64'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .imem_err_i(imem_err_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .icode_o(icode_o), .ifun_o(ifun_o), .rA_o(rA_o), .rB_o(rB_o),
    .valC_o(valC_o), .valP_o(valP_o), .stat_o(stat_o),
    .pc_load_i(pc_load_i), .pc_new_i(pc_new_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [79:0] bytes;   // byte 0 in the top eight bits
    int          nbytes;
    int          waits;
    exp_t        e;
  } vec_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     hs_cnt = 0;
  exp_t   exp_q[$];
  logic [7:0] mem [0:8191];
  int     mem_waits = 0;
  logic   err_en = 1'b0;
  logic [63:0] err_addr = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mke(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                               input logic [2:0] st);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb; e.valc = vc; e.valp = vp; e.stat = st;
    return e;
  endfunction

  task automatic mem_put(input logic [63:0] a, input logic [79:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] ad;
      ad = a + 64'(k);
      mem[ad[12:0]] = b[79 - 8*k -: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (hs_cnt < target && c < budget) begin
      tick();
      c++;
    end
    if (hs_cnt < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: handshakes %0d, required %0d", name, hs_cnt, target);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int c;
    c = 0;
    @(negedge clk_i);
    while (!valid_o && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    check(name, valid_o, 1);
  endtask

  // Memory model: responds on the falling edge after the configured wait cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (imem_req_o) begin
        if (wait_cnt >= mem_waits) begin
          imem_ack_i  = 1'b1;
          imem_data_i = mem[imem_addr_o[12:0]];
          imem_err_i  = err_en && (imem_addr_o == err_addr);
          wait_cnt    = 0;
        end else begin
          imem_ack_i = 1'b0;
          imem_err_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack_i = 1'b0;
        imem_err_i = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  // Scoreboard: every accepted bundle is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (valid_o && ready_i && !pc_load_i && !rst_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_bundle: got icode %0h valP %0h, required none", icode_o, valP_o);
        end else begin
          e = exp_q.pop_front();
          $display("bundle %0d: icode=%0h ifun=%0h rA=%0h rB=%0h valC=%0h valP=%0h stat=%0d",
                   hs_cnt, icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o, stat_o);
          check("icode", icode_o, e.icode);
          check("ifun", ifun_o, e.ifun);
          check("rA", rA_o, e.ra);
          check("rB", rB_o, e.rb);
          check("valC", valC_o, e.valc);
          check("valP", valP_o, e.valp);
          check("stat", stat_o, e.stat);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   base;
    int   cnt;

    vecs[0] = '{64'h200, 80'h10000000000000000000, 1, 0, mke(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h201, AOK)};
    vecs[1] = '{64'h210, 80'h20120000000000000000, 2, 0, mke(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h212, AOK)};
    vecs[2] = '{64'h220, 80'h61AB0000000000000000, 2, 1, mke(4'h6, 4'h1, 4'hA, 4'hB, 64'h0, 64'h222, AOK)};
    vecs[3] = '{64'h230, 80'h73887766554433221100, 9, 0,
                mke(4'h7, 4'h3, 4'hF, 4'hF, 64'h1122334455667788, 64'h239, AOK)};
    vecs[4] = '{64'h250, 80'h4015EFCDAB8967452301, 10, 2,
                mke(4'h4, 4'h0, 4'h1, 4'h5, 64'h0123456789ABCDEF, 64'h25A, AOK)};
    vecs[5] = '{64'h260, 80'h90000000000000000000, 1, 0, mke(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h261, AOK)};
    vecs[6] = '{64'h270, 80'hA02F0000000000000000, 2, 0, mke(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h272, AOK)};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h60120000000000000000, 2, 0,
                mke(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h1, AOK)};
    vecs[8] = '{64'h280, 80'hB03F0000000000000000, 2, 3, mke(4'hB, 4'h0, 4'h3, 4'hF, 64'h0, 64'h282, AOK)};

    for (int k = 0; k < 8192; k++) mem[k] = 8'h10;

    // Reset values, then nop + halt from address 0 with zero-wait memory.
    mem_put(64'h0, 80'h10006023000000000000, 4);
    rst_i = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    check("rst_valid", valid_o, 0);
    check("rst_req", imem_req_o, 0);
    check("rst_icode", icode_o, 0);
    check("rst_ifun", ifun_o, 0);
    check("rst_rA", rA_o, 4'hF);
    check("rst_rB", rB_o, 4'hF);
    check("rst_valC", valC_o, 0);
    check("rst_valP", valP_o, 0);
    check("rst_stat", stat_o, AOK);

    exp_q.push_back(mke(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, AOK));
    exp_q.push_back(mke(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2, HLT));
    ready_i = 1'b1;
    base = hs_cnt;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t1_first_req", imem_req_o, 1);
    check("t1_first_addr", imem_addr_o, 64'h0);
    check("t1_first_valid", valid_o, 0);
    @(negedge clk_i);
    check("t1_valid_after_ack", valid_o, 1);
    wait_hs(base + 2, 20, "t1");
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (imem_req_o || valid_o) cnt++;
    end
    check("t1_halted_idle", cnt, 0);

    // Table of single instructions, each started by a redirect.
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    for (int v = 0; v < 9; v++) begin
      mem_put(vecs[v].addr, vecs[v].bytes, vecs[v].nbytes);
      mem_waits = vecs[v].waits;
      exp_q.push_back(vecs[v].e);
      base = hs_cnt;
      rst_i = 1'b0;
      pc_load_i = 1'b1;
      pc_new_i = vecs[v].addr;
      tick();
      pc_load_i = 1'b0;
      wait_hs(base + 1, 200, "vec");
    end
    rst_i = 1'b1;
    ready_i = 1'b0;
    tick();
    tick();

    // irmovq with two wait cycles per byte and a three-cycle decode stall.
    mem_put(64'h0, 80'h30F20A00000000000000, 10);
    mem_waits = 2;
    exp_q.push_back(mke(4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, AOK));
    base = hs_cnt;
    rst_i = 1'b0;
    wait_valid(200, "tB_valid");
    for (int k = 0; k < 3; k++) begin
      check("tB_stall_valid", valid_o, 1);
      check("tB_stall_valC", valC_o, 64'd10);
      check("tB_stall_rB", rB_o, 4'h2);
      check("tB_stall_req", imem_req_o, 0);
      if (k < 2) @(negedge clk_i);
    end
    tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("tB_handshake", hs_cnt, base + 1);
    @(negedge clk_i);
    check("tB_next_req", imem_req_o, 1);
    check("tB_next_addr", imem_addr_o, 64'd10);

    // call, then a redirect to its target.
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    mem_put(64'h0, 80'h80341200000000000000, 9);
    mem_waits = 0;
    exp_q.push_back(mke(4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'd9, AOK));
    base = hs_cnt;
    ready_i = 1'b1;
    rst_i = 1'b0;
    wait_hs(base + 1, 50, "tC");
    ready_i = 1'b0;
    pc_load_i = 1'b1;
    pc_new_i = 64'h1234;
    tick();
    pc_load_i = 1'b0;
    @(negedge clk_i);
    check("tC_redirect_req", imem_req_o, 1);
    check("tC_redirect_addr", imem_addr_o, 64'h1234);

    // Redirect while a bundle is pending drops it even with ready high.
    mem_put(64'h1234, 80'h10000000000000000000, 1);
    wait_valid(20, "tC_nop_valid");
    base = hs_cnt;
    tick();
    ready_i = 1'b1;
    pc_load_i = 1'b1;
    pc_new_i = 64'h300;
    tick();
    pc_load_i = 1'b0;
    ready_i = 1'b0;
    check("tC_dropped", hs_cnt, base);
    @(negedge clk_i);
    check("tC_drop_req", imem_req_o, 1);
    check("tC_drop_addr", imem_addr_o, 64'h300);

    // Invalid icode, then HALTED ignores a redirect.
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    mem_put(64'h0, 80'hC0000000000000000000, 1);
    exp_q.push_back(mke(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, INS));
    base = hs_cnt;
    ready_i = 1'b1;
    rst_i = 1'b0;
    wait_hs(base + 1, 20, "tD");
    pc_load_i = 1'b1;
    pc_new_i = 64'h500;
    tick();
    pc_load_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (imem_req_o || valid_o) cnt++;
    end
    check("tD_halted_idle", cnt, 0);

    // mrmovq at 0x40 with a fault on byte 3.
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    mem_put(64'h40, 80'h50120000000000000000, 10);
    err_en = 1'b1;
    err_addr = 64'h43;
    exp_q.push_back(mke(4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 64'h44, ADR));
    base = hs_cnt;
    rst_i = 1'b0;
    pc_load_i = 1'b1;
    pc_new_i = 64'h40;
    tick();
    pc_load_i = 1'b0;
    wait_hs(base + 1, 30, "tE");
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (imem_req_o) cnt++;
    end
    check("tE_halted_req", cnt, 0);
    err_en = 1'b0;

    // Redirect in the middle of an irmovq, then reset while in OUT.
    tick();
    rst_i = 1'b1;
    ready_i = 1'b0;
    tick();
    tick();
    mem_put(64'h0, 80'h30F21122334455667788, 10);
    mem_put(64'h100, 80'h10000000000000000000, 1);
    rst_i = 1'b0;
    tick();
    cnt = 0;
    while (!(imem_req_o && imem_addr_o == 64'd5) && cnt < 50) begin
      tick();
      cnt++;
    end
    check("tF_reached_byte5", imem_addr_o, 64'd5);
    base = hs_cnt;
    pc_load_i = 1'b1;
    pc_new_i = 64'h100;
    tick();
    pc_load_i = 1'b0;
    @(negedge clk_i);
    check("tF_redirect_req", imem_req_o, 1);
    check("tF_redirect_addr", imem_addr_o, 64'h100);
    wait_valid(20, "tF_nop_valid");
    check("tF_bundle_icode", icode_o, 4'h1);
    check("tF_bundle_valP", valP_o, 64'h101);
    check("tF_no_partial", hs_cnt, base);
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("tF_rst_valid", valid_o, 0);
    check("tF_rst_req", imem_req_o, 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("tF_after_rst_valid", valid_o, 0);
    check("tF_after_rst_req", imem_req_o, 1);
    check("tF_after_rst_addr", imem_addr_o, 64'h0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
